branch_resolve_ctrl: RTL and testbench



---
 rtl/branch_resolve_ctrl_pkg.sv | 48 ++++
 rtl/branch_resolve_ctrl_if.sv | 46 ++++
 rtl/branch_resolve_ctrl_zero_detector.sv | 11 +
 rtl/branch_resolve_ctrl.sv | 171 +++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared MIPS branch definitions: branch opcode encodings, controller state
// encoding, default sizing and small arithmetic helpers used by the branch
// resolution controller.
package mips_pkg;

  typedef enum logic [1:0] {
    BR_BEQ  = 2'b00,
    BR_BNE  = 2'b01,
    BR_BLEZ = 2'b10,
    BR_BGTZ = 2'b11
  } br_op_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_EVAL     = 2'b01,
    S_REDIRECT = 2'b10,
    S_FLUSH    = 2'b11
  } br_state_t;

  localparam int FLUSH_SLOTS_DEFAULT = 2;
  localparam int WIDTH_DEFAULT       = 32;
  localparam int FLUSH_CNT_W         = 3;

  // Branch outcome from the zero flag and the sign of rs.
  function automatic logic br_taken(input br_op_t op, input logic zero, input logic sign);
    logic t;
    case (op)
      BR_BEQ:  t = zero;
      BR_BNE:  t = ~zero;
      BR_BLEZ: t = zero | sign;
      BR_BGTZ: t = ~zero & ~sign;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // 32-bit increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Branch request / resolution bus between the hazard unit side (master) and
// the branch resolution controller (slave).
// Optional statistics signals are present when BRANCH_STATS_EN is defined.
interface branch_resolve_ctrl_if #(parameter int WIDTH = 32);

  logic             br_valid;
  logic [1:0]       br_op;
  logic [WIDTH-1:0] br_a;
  logic [WIDTH-1:0] br_b;
  logic [WIDTH-1:0] br_target;
  logic             stall;
  logic             br_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             pc_load;
  logic [WIDTH-1:0] pc_target;
  logic             flush;
`ifdef BRANCH_STATS_EN
  logic             stat_clr;
  logic [31:0]      stat_taken;
  logic [31:0]      stat_not_taken;

  modport master (
    output br_valid, br_op, br_a, br_b, br_target, stall, stat_clr,
    input  br_ready, resolve_valid, resolve_taken, pc_load, pc_target, flush,
           stat_taken, stat_not_taken
  );

  modport slave (
    input  br_valid, br_op, br_a, br_b, br_target, stall, stat_clr,
    output br_ready, resolve_valid, resolve_taken, pc_load, pc_target, flush,
           stat_taken, stat_not_taken
  );
`else
  modport master (
    output br_valid, br_op, br_a, br_b, br_target, stall,
    input  br_ready, resolve_valid, resolve_taken, pc_load, pc_target, flush
  );

  modport slave (
    input  br_valid, br_op, br_a, br_b, br_target, stall,
    output br_ready, resolve_valid, resolve_taken, pc_load, pc_target, flush
  );
`endif

endinterface

// File: rtl/branch_resolve_ctrl_zero_detector.sv
// Shared zero detector: flags an all-zero operand difference.
module zero_detector #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  assign zero = (value == {WIDTH{1'b0}});

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the pipelined MIPS core.
// Accepts a branch in IDLE, evaluates it through the shared zero detector,
// then on a taken branch issues a one-cycle PC redirect followed by a
// flush lasting FLUSH_SLOTS cycles in total.
// Optional: define BRANCH_STATS_EN to add saturating taken/not-taken counters.
module branch_resolve_ctrl
  import mips_pkg::*;
#(
  parameter int FLUSH_SLOTS = FLUSH_SLOTS_DEFAULT,
  parameter int WIDTH       = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_ctrl_if.slave bus
);

  // Counter reload value on leaving REDIRECT (slots still to flush).
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_SLOTS - 1);

  br_state_t              state;
  br_op_t                 op_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [WIDTH-1:0]       target_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt;

  logic                   br_ready_q;
  logic                   resolve_valid_q;
  logic                   resolve_taken_q;
  logic                   pc_load_q;
  logic [WIDTH-1:0]       pc_target_q;
  logic                   flush_q;

  logic [WIDTH-1:0]       diff;
  logic                   zero;
  logic                   taken;

  // Operand difference; sign-tests against zero pass rs straight through.
  always_comb begin
    diff = a_q;
    if ((op_q == BR_BEQ) || (op_q == BR_BNE)) begin
      diff = a_q - b_q;
    end else begin
      diff = a_q;
    end
  end

  zero_detector #(.WIDTH(WIDTH)) u_zero_detector (
    .value (diff),
    .zero  (zero)
  );

  assign taken = br_taken(op_q, zero, a_q[WIDTH-1]);

  // Control FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      op_q            <= BR_BEQ;
      a_q             <= {WIDTH{1'b0}};
      b_q             <= {WIDTH{1'b0}};
      target_q        <= {WIDTH{1'b0}};
      flush_cnt       <= {FLUSH_CNT_W{1'b0}};
      br_ready_q      <= 1'b1;
      resolve_valid_q <= 1'b0;
      resolve_taken_q <= 1'b0;
      pc_load_q       <= 1'b0;
      pc_target_q     <= {WIDTH{1'b0}};
      flush_q         <= 1'b0;
    end else begin
      resolve_valid_q <= 1'b0;
      resolve_taken_q <= 1'b0;
      pc_load_q       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.br_valid && !bus.stall) begin
            op_q       <= br_op_t'(bus.br_op);
            a_q        <= bus.br_a;
            b_q        <= bus.br_b;
            target_q   <= bus.br_target;
            br_ready_q <= 1'b0;
            state      <= S_EVAL;
          end else begin
            br_ready_q <= 1'b1;
          end
        end
        S_EVAL: begin
          if (!bus.stall) begin
            resolve_valid_q <= 1'b1;
            resolve_taken_q <= taken;
            if (taken) begin
              pc_load_q   <= 1'b1;
              pc_target_q <= target_q;
              flush_q     <= 1'b1;
              state       <= S_REDIRECT;
            end else begin
              br_ready_q  <= 1'b1;
              state       <= S_IDLE;
            end
          end else begin
            state <= S_EVAL;
          end
        end
        S_REDIRECT: begin
          // Redirect is never held off by stall.
          if (FLUSH_SLOTS > 1) begin
            flush_cnt <= FLUSH_INIT;
            state     <= S_FLUSH;
          end else begin
            flush_q    <= 1'b0;
            br_ready_q <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_FLUSH: begin
          // Counts down regardless of stall so the flush length is fixed.
          if (flush_cnt <= FLUSH_CNT_W'(1)) begin
            flush_cnt  <= {FLUSH_CNT_W{1'b0}};
            flush_q    <= 1'b0;
            br_ready_q <= 1'b1;
            state      <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
          end
        end
        default: begin
          flush_cnt  <= {FLUSH_CNT_W{1'b0}};
          flush_q    <= 1'b0;
          br_ready_q <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.br_ready      = br_ready_q;
  assign bus.resolve_valid = resolve_valid_q;
  assign bus.resolve_taken = resolve_taken_q;
  assign bus.pc_load       = pc_load_q;
  assign bus.pc_target     = pc_target_q;
  assign bus.flush         = flush_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken_q;
  logic [31:0] stat_not_taken_q;

  // Saturating outcome counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_taken_q     <= 32'd0;
      stat_not_taken_q <= 32'd0;
    end else if (bus.stat_clr) begin
      stat_taken_q     <= 32'd0;
      stat_not_taken_q <= 32'd0;
    end else if (resolve_valid_q) begin
      if (resolve_taken_q) begin
        stat_taken_q     <= sat_inc32(stat_taken_q);
      end else begin
        stat_not_taken_q <= sat_inc32(stat_not_taken_q);
      end
    end else begin
      stat_taken_q     <= stat_taken_q;
      stat_not_taken_q <= stat_not_taken_q;
    end
  end

  assign bus.stat_taken     = stat_taken_q;
  assign bus.stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized self-checking bench for branch_resolve_ctrl. A transaction-level
// model turns each accepted branch into a schedule of expected per-cycle
// outputs (busy window, resolve pulse, redirect, flush window), using the
// pre-drawn stall pattern to locate the resolve cycle.
// Honors BRANCH_STATS_EN when it is defined for the build.
module tb_branch_resolve_ctrl;

  localparam int W      = 32;
  localparam int FS     = 2;
  localparam int NCYC   = 1500;
  localparam int NDRAIN = 24;
  localparam int NARR   = NCYC + NDRAIN + 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  branch_resolve_ctrl_if #(.WIDTH(W)) bus();

  branch_resolve_ctrl #(.FLUSH_SLOTS(FS), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = -1;

  // Expected per-cycle outputs, indexed by cycle number.
  bit          stall_a [NARR];
  bit          e_ready [NARR];
  bit          e_rv    [NARR];
  bit          e_tk    [NARR];
  bit          e_pl    [NARR];
  bit          e_fl    [NARR];
  logic [31:0] e_pt    [NARR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'hFFFF_FFFF;
      5: v = 32'($urandom_range(0, 3));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Branch accepted at cycle c: lay out everything it should cause.
  task automatic schedule(input int c, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] tgt);
    int  e;
    bit  tk;
    e = c + 1;
    while (stall_a[e] && e < NARR - FS - 2) e++;
    for (int k = c + 1; k <= e; k++) e_ready[k] = 1'b0;
    case (op)
      2'd0:    tk = (a == b);
      2'd1:    tk = (a != b);
      2'd2:    tk = ($signed(a) <= 0);
      default: tk = ($signed(a) > 0);
    endcase
    e_rv[e+1] = 1'b1;
    e_tk[e+1] = tk;
    if (tk) begin
      e_pl[e+1] = 1'b1;
      for (int k = e + 1; k <= e + FS; k++) begin
        e_fl[k]    = 1'b1;
        e_ready[k] = 1'b0;
      end
      for (int k = e + 1; k < NARR; k++) e_pt[k] = tgt;
    end
  endtask

  bit          pending;
  logic [1:0]  p_op;
  logic [31:0] p_a, p_b, p_t;
  bit          clr_now;
  int          x_st_t, x_st_nt;

  initial begin
    for (int i = 0; i < NARR; i++) begin
      stall_a[i] = (i < NCYC) && ($urandom_range(0, 3) == 0);
      e_ready[i] = 1'b1;
      e_rv[i]    = 1'b0;
      e_tk[i]    = 1'b0;
      e_pl[i]    = 1'b0;
      e_fl[i]    = 1'b0;
      e_pt[i]    = 32'h0;
    end
    pending = 1'b0;
    p_op = 2'd0; p_a = 32'h0; p_b = 32'h0; p_t = 32'h0;
    clr_now = 1'b0;
    x_st_t = 0; x_st_nt = 0;
    bus.br_valid = 1'b0; bus.br_op = 2'd0; bus.br_a = 32'h0; bus.br_b = 32'h0;
    bus.br_target = 32'h0; bus.stall = 1'b0;
`ifdef BRANCH_STATS_EN
    bus.stat_clr = 1'b0;
`endif

    // Values held while reset is asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.br_ready, 1);
    check("rst_rv", bus.resolve_valid, 0);
    check("rst_taken", bus.resolve_taken, 0);
    check("rst_pc_load", bus.pc_load, 0);
    check("rst_pc_target", bus.pc_target, 0);
    check("rst_flush", bus.flush, 0);
    @(negedge clk);
    reset = 1'b0;

    // Random phase: inputs driven just after each rising edge, outputs
    // compared at the falling edge of the same cycle.
    for (int c = 0; c < NCYC + NDRAIN; c++) begin
      @(posedge clk);
      #1;
      if (!pending && c < NCYC && $urandom_range(0, 2) != 0) begin
        pending = 1'b1;
        p_op = 2'($urandom_range(0, 3));
        p_a  = pick_val();
        p_b  = ($urandom_range(0, 1) == 1) ? p_a : pick_val();
        p_t  = $urandom;
      end
      bus.br_valid  = pending;
      bus.br_op     = p_op;
      bus.br_a      = p_a;
      bus.br_b      = p_b;
      bus.br_target = p_t;
      bus.stall     = stall_a[c];
      clr_now       = (c < NCYC) && ($urandom_range(0, 39) == 0);
`ifdef BRANCH_STATS_EN
      bus.stat_clr  = clr_now;
`endif
      @(negedge clk);
      cyc = c;
      check("br_ready", bus.br_ready, e_ready[c]);
      check("resolve_valid", bus.resolve_valid, e_rv[c]);
      check("resolve_taken", bus.resolve_taken, e_tk[c]);
      check("pc_load", bus.pc_load, e_pl[c]);
      check("pc_target", bus.pc_target, e_pt[c]);
      check("flush", bus.flush, e_fl[c]);
`ifdef BRANCH_STATS_EN
      check("stat_taken", bus.stat_taken, x_st_t);
      check("stat_not_taken", bus.stat_not_taken, x_st_nt);
      if (clr_now) begin
        x_st_t = 0; x_st_nt = 0;
      end else if (e_rv[c]) begin
        if (e_tk[c]) x_st_t++; else x_st_nt++;
      end
`endif
      if (pending && e_ready[c] && !stall_a[c]) begin
        schedule(c, p_op, p_a, p_b, p_t);
        pending = 1'b0;
      end
    end

    // Directed: reset landing in the redirect cycle of a taken BEQ.
    @(posedge clk);
    #1;
    bus.br_valid = 1'b1; bus.br_op = 2'd0; bus.br_a = 32'h0000_1234;
    bus.br_b = 32'h0000_1234; bus.br_target = 32'h0040_0100; bus.stall = 1'b0;
`ifdef BRANCH_STATS_EN
    bus.stat_clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    bus.br_valid = 1'b0;
    @(posedge clk);
    #2;
    cyc = -2;
    check("redir_pc_load", bus.pc_load, 1);
    check("redir_pc_target", bus.pc_target, 32'h0040_0100);
    check("redir_taken", bus.resolve_taken, 1);
    check("redir_flush", bus.flush, 1);
    reset = 1'b1;
    #1;
    check("async_pc_load", bus.pc_load, 0);
    check("async_rv", bus.resolve_valid, 0);
    check("async_flush", bus.flush, 0);
    check("async_pc_target", bus.pc_target, 0);
    check("async_ready", bus.br_ready, 1);
`ifdef BRANCH_STATS_EN
    check("async_stat_t", bus.stat_taken, 0);
    check("async_stat_nt", bus.stat_not_taken, 0);
`endif
    #2;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cyc = -3 - k;
      check("post_ready", bus.br_ready, 1);
      check("post_pc_load", bus.pc_load, 0);
      check("post_flush", bus.flush, 0);
      check("post_rv", bus.resolve_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
